power_mode_ctrl: RTL and testbench
==================================

POWER_MODE_CTRL -- requirements
Module: power_mode_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000: sys_clk cycles per timing tick.
REQ-002 SHALL have parameter HOLD_TICKS, default 100: ticks power_on_btn must be held to power on.
REQ-003 SHALL have parameter DEBOUNCE_TICKS, default 2: ticks mode_sel must be stable before acceptance.
REQ-004 SHALL have parameter IDLE_TICKS, default 0: ticks without activity before auto power-off; 0 disables.
REQ-005 SHALL have parameter NUM_MODES, default 3: number of one-hot mode switches, range 2..8.
REQ-006 SHALL have ports: sys_clk, in, 1, sole clock, all logic on its rising edge.
REQ-007 SHALL have ports: rst, in, 1, synchronous active-high reset.
REQ-008 SHALL have ports: power_on_btn, in, 1, active-high power-on request.
REQ-009 SHALL have ports: power_off_btn, in, 1, active-high power-off request.
REQ-010 SHALL have ports: mode_sel, in, NUM_MODES, raw mode switches.
REQ-011 SHALL have ports: activity, in, 1, high while any drive command is asserted.
REQ-012 SHALL have ports: power_on_led, out, 1, high in state ON.
REQ-013 SHALL have ports: mode_onehot, out, NUM_MODES, accepted mode, all-zero when none or off.
REQ-014 SHALL have ports: off_cause, out, 2, 00 none, 01 button, 10 idle timeout; held until next power-on.
REQ-015 SHALL have ports: off_pulse, out, 1, one-cycle pulse on every ON->OFF transition.

Function
REQ-016 SHALL pass power_on_btn, power_off_btn, mode_sel, activity through a 2-flop synchronizer; all logic below uses synchronized values.
REQ-017 SHALL implement FSM states OFF, HOLD, ON.
REQ-018 OFF->HOLD SHALL occur when on=1 and off=0; entering HOLD clears tick divider and hold counter.
REQ-019 HOLD->OFF SHALL occur when on=0 or off=1; hold counter cleared, off_cause unchanged.
REQ-020 HOLD->ON SHALL occur on the tick where hold counter equals HOLD_TICKS-1, i.e. exactly 3+TICK_DIV*HOLD_TICKS edges after raw button rise.
REQ-021 ON->OFF SHALL occur on the edge after synchronized off=1, setting off_cause=01 and off_pulse=1, regardless of on.
REQ-022 ON->OFF SHALL occur when IDLE_TICKS>0 and the idle counter reaches IDLE_TICKS-1 on a tick with activity=0, setting off_cause=10 and off_pulse=1; activity=1 clears idle counter.
REQ-023 Simultaneous idle expiry and off SHALL report off_cause=01.
REQ-024 Entering ON SHALL clear off_cause to 00 and idle counter.
REQ-025 Tick SHALL be a one-cycle pulse every TICK_DIV cycles, free-running except cleared on HOLD entry.
REQ-026 In ON the mode filter SHALL load a candidate when synchronized mode_sel differs from it, clearing its stable counter.
REQ-027 When the candidate has been stable for DEBOUNCE_TICKS ticks, mode_onehot SHALL take the candidate if exactly one bit is set, else all-zero.
REQ-028 Outside ON, mode_onehot, candidate and stable counter SHALL be zero; first acceptance after power-on follows REQ-027.
REQ-029 Counters SHALL saturate, never wrap, and be sized clog2 of their terminal value plus 1.

Reset
REQ-030 rst SHALL force state OFF, all counters and synchronizers zero, power_on_led=0, mode_onehot=0, off_cause=00, off_pulse=0 on the next edge, overriding any in-progress hold or idle count.

Structure
REQ-031 State encoding and off_cause codes SHALL live in a shared package power_mode_pkg.
REQ-032 Tick divider SHALL be sub-module tick_gen (parameter TICK_DIV, inputs sys_clk, rst, clr; output tick).

Verification (TICK_DIV=4, HOLD_TICKS=3, DEBOUNCE_TICKS=2, IDLE_TICKS=5, NUM_MODES=3)
REQ-033 Hold power_on_btn from edge 0 -> power_on_led rises at edge 15; release at edge 10 -> stays 0, state OFF.
REQ-034 ON, mode_sel=010 stable -> mode_onehot=010 after 2 ticks; mode_sel=011 -> mode_onehot=000; 010 glitch for 1 tick -> no change.
REQ-035 ON, pulse power_off_btn 1 cycle -> off_pulse 1 cycle 3 edges later, off_cause=01, mode_onehot=000.
REQ-036 ON, activity=0 -> off after 5 ticks, off_cause=10; activity pulse each 3 ticks -> stays ON.
REQ-037 Both buttons held from OFF -> never enters ON; both in ON -> OFF, off_cause=01.
REQ-038 rst asserted mid-HOLD at tick 2 -> OFF next edge, later full hold still needs 3 ticks.

Source files
------------

// File: rtl/power_mode_pkg.sv
// Shared state encoding, power-off cause codes and counter sizing helper
// for the power mode controller.
package power_mode_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_HOLD = 2'd1,
        ST_ON   = 2'd2
    } pm_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_BUTTON = 2'b01,
        CAUSE_IDLE   = 2'b10
    } off_cause_e;

    // Bits needed to hold every value 0..terminal, never narrower than one bit.
    function automatic int cnt_width(input int terminal);
        return (terminal < 32'sd1) ? 32'sd1 : $clog2(terminal + 32'sd1);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running timing tick: one-cycle registered pulse every TICK_DIV cycles,
// restarted from zero whenever clr is asserted.
module tick_gen
    import power_mode_pkg::*;
#(
    parameter int TICK_DIV = 32'sd50000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = cnt_width(TICK_DIV - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 32'sd1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Divider counter and registered tick pulse
    always_ff @(posedge sys_clk) begin
        if (rst || clr) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/power_mode_ctrl.sv
// Power mode controller: press-and-hold power-on, button or idle power-off,
// and a debounced one-hot mode selector that is only live while powered.
module power_mode_ctrl
    import power_mode_pkg::*;
#(
    parameter int TICK_DIV       = 32'sd50000,
    parameter int HOLD_TICKS     = 32'sd100,
    parameter int DEBOUNCE_TICKS = 32'sd2,
    parameter int IDLE_TICKS     = 32'sd0,
    parameter int NUM_MODES      = 32'sd3
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 power_on_btn,
    input  logic                 power_off_btn,
    input  logic [NUM_MODES-1:0] mode_sel,
    input  logic                 activity,
    output logic                 power_on_led,
    output logic [NUM_MODES-1:0] mode_onehot,
    output logic [1:0]           off_cause,
    output logic                 off_pulse
);

    localparam int SYNC_W = NUM_MODES + 32'sd3;
    localparam int HOLD_W = cnt_width(HOLD_TICKS);
    localparam int IDLE_W = cnt_width(IDLE_TICKS);
    localparam int DEB_W  = cnt_width(DEBOUNCE_TICKS);
    localparam bit IDLE_EN = (IDLE_TICKS > 32'sd0);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 32'sd1);
    localparam logic [HOLD_W-1:0] HOLD_FULL = HOLD_W'(HOLD_TICKS);
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        IDLE_W'((IDLE_TICKS > 32'sd0) ? IDLE_TICKS - 32'sd1 : 32'sd0);
    localparam logic [IDLE_W-1:0] IDLE_FULL = IDLE_W'(IDLE_TICKS);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_TICKS - 32'sd1);
    localparam logic [DEB_W-1:0]  DEB_FULL  = DEB_W'(DEBOUNCE_TICKS);

    logic [SYNC_W-1:0]    sync1_r;
    logic [SYNC_W-1:0]    sync2_r;
    logic                 on_s;
    logic                 off_s;
    logic                 act_s;
    logic [NUM_MODES-1:0] mode_s;
    logic                 tick_s;

    pm_state_e            state_r;
    pm_state_e            state_next_s;
    logic                 hold_entry_s;
    logic                 off_btn_s;
    logic                 idle_exp_s;
    logic                 mode_run_s;
    logic                 cand_onehot_s;

    logic [HOLD_W-1:0]    hold_cnt_r;
    logic [IDLE_W-1:0]    idle_cnt_r;
    logic [DEB_W-1:0]     stable_cnt_r;
    logic [NUM_MODES-1:0] cand_r;
    logic [NUM_MODES-1:0] mode_r;
    logic                 led_r;
    logic                 pulse_r;
    off_cause_e           cause_r;

    // Two-flop synchronizer for every asynchronous input
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= {power_on_btn, power_off_btn, activity, mode_sel};
            sync2_r <= sync1_r;
        end
    end

    assign on_s   = sync2_r[SYNC_W-1];
    assign off_s  = sync2_r[SYNC_W-2];
    assign act_s  = sync2_r[SYNC_W-3];
    assign mode_s = sync2_r[NUM_MODES-1:0];

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clr     (hold_entry_s),
        .tick    (tick_s)
    );

    // Next-state logic; the off button outranks an idle expiry in the same cycle
    always_comb begin
        state_next_s = state_r;
        hold_entry_s = 1'b0;
        off_btn_s    = 1'b0;
        idle_exp_s   = 1'b0;
        case (state_r)
            ST_OFF: begin
                if (on_s && !off_s) begin
                    state_next_s = ST_HOLD;
                    hold_entry_s = 1'b1;
                end else begin
                    state_next_s = ST_OFF;
                end
            end
            ST_HOLD: begin
                if (!on_s || off_s) begin
                    state_next_s = ST_OFF;
                end else if (tick_s && (hold_cnt_r == HOLD_LAST)) begin
                    state_next_s = ST_ON;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_ON: begin
                if (off_s) begin
                    state_next_s = ST_OFF;
                    off_btn_s    = 1'b1;
                end else if (IDLE_EN && !act_s && tick_s && (idle_cnt_r == IDLE_LAST)) begin
                    state_next_s = ST_OFF;
                    idle_exp_s   = 1'b1;
                end else begin
                    state_next_s = ST_ON;
                end
            end
            default: begin
                state_next_s = ST_OFF;
            end
        endcase
    end

    // State register and registered status outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r <= ST_OFF;
            led_r   <= 1'b0;
            pulse_r <= 1'b0;
            cause_r <= CAUSE_NONE;
        end else begin
            state_r <= state_next_s;
            led_r   <= (state_next_s == ST_ON);
            pulse_r <= off_btn_s || idle_exp_s;
            if ((state_r != ST_ON) && (state_next_s == ST_ON)) begin
                cause_r <= CAUSE_NONE;
            end else if (off_btn_s) begin
                cause_r <= CAUSE_BUTTON;
            end else if (idle_exp_s) begin
                cause_r <= CAUSE_IDLE;
            end else begin
                cause_r <= cause_r;
            end
        end
    end

    // Hold counter: ticks spent in HOLD, zero whenever HOLD is entered or left
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            hold_cnt_r <= '0;
        end else if ((state_r == ST_HOLD) && (state_next_s == ST_HOLD)) begin
            if (tick_s && (hold_cnt_r != HOLD_FULL)) begin
                hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
        end else begin
            hold_cnt_r <= '0;
        end
    end

    // Idle counter: activity-free ticks while staying ON
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            idle_cnt_r <= '0;
        end else if ((state_r == ST_ON) && (state_next_s == ST_ON)) begin
            if (act_s) begin
                idle_cnt_r <= '0;
            end else if (tick_s && (idle_cnt_r != IDLE_FULL)) begin
                idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
            end else begin
                idle_cnt_r <= idle_cnt_r;
            end
        end else begin
            idle_cnt_r <= '0;
        end
    end

    // The filter only runs across consecutive ON cycles, so it restarts empty at power-on
    assign mode_run_s    = (state_r == ST_ON) && (state_next_s == ST_ON);
    assign cand_onehot_s = (cand_r != '0) && ((cand_r & (cand_r - NUM_MODES'(1))) == '0);

    // Mode debounce filter and accepted-mode register
    always_ff @(posedge sys_clk) begin
        if (rst || !mode_run_s) begin
            cand_r       <= '0;
            stable_cnt_r <= '0;
            mode_r       <= '0;
        end else if (mode_s != cand_r) begin
            cand_r       <= mode_s;
            stable_cnt_r <= '0;
        end else if (tick_s && (stable_cnt_r != DEB_FULL)) begin
            stable_cnt_r <= stable_cnt_r + DEB_W'(1);
            if (stable_cnt_r == DEB_LAST) begin
                mode_r <= cand_onehot_s ? cand_r : '0;
            end else begin
                mode_r <= mode_r;
            end
        end else begin
            stable_cnt_r <= stable_cnt_r;
        end
    end

    assign power_on_led = led_r;
    assign mode_onehot  = mode_r;
    assign off_cause    = cause_r;
    assign off_pulse    = pulse_r;

endmodule

// File: tb/tb_power_mode_ctrl.sv
// Self-checking bench for power_mode_ctrl: directed scenarios with literal
// expectations plus randomized traffic, all checked against a behavioural model.
module tb_power_mode_ctrl;

    localparam int TICK_DIV = 4;
    localparam int HOLD     = 3;
    localparam int DEB      = 2;
    localparam int IDLE     = 5;
    localparam int NM       = 3;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          on_btn;
    logic          off_btn;
    logic          act;
    logic [NM-1:0] mode_sel;
    logic          led;
    logic [NM-1:0] mode_oh;
    logic [1:0]    cause;
    logic          pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: powered/holding flags, tick counts, raw-input history
    int            cyc = 0;
    int            origin = 0;
    int            held = 0;
    int            idle_ticks = 0;
    int            stab = 0;
    bit            m_hold = 1'b0;
    bit            m_on = 1'b0;
    bit            m_pulse = 1'b0;
    logic [1:0]    m_cause = 2'b00;
    logic [NM-1:0] cand = '0;
    logic [NM-1:0] acc = '0;
    logic [NM+2:0] hist[2];

    power_mode_ctrl #(
        .TICK_DIV       (TICK_DIV),
        .HOLD_TICKS     (HOLD),
        .DEBOUNCE_TICKS (DEB),
        .IDLE_TICKS     (IDLE),
        .NUM_MODES      (NM)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .power_on_btn  (on_btn),
        .power_off_btn (off_btn),
        .mode_sel      (mode_sel),
        .activity      (act),
        .power_on_led  (led),
        .mode_onehot   (mode_oh),
        .off_cause     (cause),
        .off_pulse     (pulse)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, actual, expected);
        end
    endtask

    // One rising edge of the specification's rules, using inputs as seen two edges late.
    task automatic model_step();
        bit            s_on;
        bit            s_off;
        bit            s_act;
        logic [NM-1:0] s_mode;
        bit            tk;
        bit            was_on;
        int            since;
        {s_on, s_off, s_act, s_mode} = hist[1];
        if (rst) begin
            hist[0] = '0;
            hist[1] = '0;
            origin = cyc;
            m_hold = 1'b0;
            m_on = 1'b0;
            m_pulse = 1'b0;
            m_cause = 2'b00;
            held = 0;
            idle_ticks = 0;
            cand = '0;
            stab = 0;
            acc = '0;
            cyc++;
            return;
        end
        hist[1] = hist[0];
        hist[0] = {on_btn, off_btn, act, mode_sel};
        since = cyc - origin - 1;
        tk = (since >= TICK_DIV) && ((since % TICK_DIV) == 0);
        was_on = m_on;
        m_pulse = 1'b0;
        if (m_on) begin
            if (s_off) begin
                m_on = 1'b0;
                m_cause = 2'b01;
                m_pulse = 1'b1;
            end else begin
                if (s_act) idle_ticks = 0;
                else if (tk) idle_ticks++;
                if (idle_ticks == IDLE) begin
                    m_on = 1'b0;
                    m_cause = 2'b10;
                    m_pulse = 1'b1;
                end
            end
        end else if (m_hold) begin
            if (!s_on || s_off) begin
                m_hold = 1'b0;
            end else if (tk) begin
                held++;
                if (held == HOLD) begin
                    m_hold = 1'b0;
                    m_on = 1'b1;
                    m_cause = 2'b00;
                    idle_ticks = 0;
                end
            end
        end else if (s_on && !s_off) begin
            m_hold = 1'b1;
            held = 0;
            origin = cyc;
        end
        if (was_on && m_on) begin
            if (s_mode != cand) begin
                cand = s_mode;
                stab = 0;
            end else if (tk && stab < DEB) begin
                stab++;
                if (stab == DEB) acc = ($countones(cand) == 1) ? cand : '0;
            end
        end else begin
            cand = '0;
            stab = 0;
            acc = '0;
        end
        cyc++;
    endtask

    // Advance one clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        check("led", 8'(led), 8'(m_on));
        check("mode", 8'(mode_oh), 8'(acc));
        check("cause", 8'(cause), 8'(m_cause));
        check("pulse", 8'(pulse), 8'(m_pulse));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        on_btn = 1'b0;
        off_btn = 1'b0;
        act = 1'b0;
        mode_sel = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Reset, then hold the on button through exactly edge 15 and release it.
    task automatic power_up();
        do_reset();
        on_btn = 1'b1;
        repeat (16) step();
        on_btn = 1'b0;
    endtask

    initial begin
        hist[0] = '0;
        hist[1] = '0;
        do_reset();
        check("lit_reset_led", 8'(led), 8'd0);
        check("lit_reset_mode", 8'(mode_oh), 8'd0);
        check("lit_reset_cause", 8'(cause), 8'd0);
        check("lit_reset_pulse", 8'(pulse), 8'd0);

        // Full hold: LED rises exactly at edge 15
        on_btn = 1'b1;
        repeat (15) step();
        check("lit_hold_edge14", 8'(led), 8'd0);
        step();
        check("lit_hold_edge15", 8'(led), 8'd1);

        // Release at edge 10: never powers on
        do_reset();
        on_btn = 1'b1;
        repeat (10) step();
        on_btn = 1'b0;
        repeat (20) step();
        check("lit_short_hold", 8'(led), 8'd0);

        // Mode filter: one-hot accepted, multi-hot rejected, short glitch ignored
        power_up();
        act = 1'b1;
        mode_sel = 3'b010;
        repeat (20) step();
        check("lit_mode_010", 8'(mode_oh), 8'h2);
        mode_sel = 3'b011;
        repeat (20) step();
        check("lit_mode_011", 8'(mode_oh), 8'h0);
        mode_sel = 3'b010;
        repeat (4) step();
        mode_sel = 3'b011;
        repeat (20) step();
        check("lit_mode_glitch", 8'(mode_oh), 8'h0);

        // Off button pulse
        mode_sel = 3'b001;
        repeat (20) step();
        off_btn = 1'b1;
        step();
        off_btn = 1'b0;
        step();
        check("lit_offpulse_early", 8'(pulse), 8'd0);
        step();
        check("lit_offpulse", 8'(pulse), 8'd1);
        check("lit_off_cause_btn", 8'(cause), 8'h1);
        check("lit_off_mode", 8'(mode_oh), 8'h0);
        step();
        check("lit_offpulse_end", 8'(pulse), 8'd0);

        // Idle timeout: fifth activity-free tick in ON lands on edge 35
        power_up();
        act = 1'b0;
        repeat (19) step();
        check("lit_idle_edge34", 8'(led), 8'd1);
        step();
        check("lit_idle_edge35", 8'(led), 8'd0);
        check("lit_idle_cause", 8'(cause), 8'h2);

        // Activity every three ticks keeps power on
        power_up();
        for (int k = 0; k < 10; k++) begin
            act = 1'b0;
            repeat (11) step();
            act = 1'b1;
            step();
        end
        act = 1'b0;
        check("lit_activity_keeps_on", 8'(led), 8'd1);

        // Both buttons: never powers on from OFF; powers off from ON
        do_reset();
        on_btn = 1'b1;
        off_btn = 1'b1;
        repeat (40) step();
        check("lit_both_from_off", 8'(led), 8'd0);
        power_up();
        on_btn = 1'b1;
        off_btn = 1'b1;
        repeat (3) step();
        check("lit_both_in_on", 8'(led), 8'd0);
        check("lit_both_cause", 8'(cause), 8'h1);
        on_btn = 1'b0;
        off_btn = 1'b0;

        // Reset at the second hold tick, then a full hold is needed again
        do_reset();
        on_btn = 1'b1;
        repeat (11) step();
        rst = 1'b1;
        step();
        check("lit_rst_mid_hold", 8'(led), 8'd0);
        rst = 1'b0;
        repeat (15) step();
        check("lit_rehold_early", 8'(led), 8'd0);
        step();
        check("lit_rehold_on", 8'(led), 8'd1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(29, 0) == 0) on_btn = ~on_btn;
            off_btn = ($urandom_range(79, 0) == 0);
            if ($urandom_range(14, 0) == 0) act = ~act;
            if ($urandom_range(19, 0) == 0) mode_sel = NM'($urandom_range(7, 0));
            rst = ($urandom_range(699, 0) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
